// File: rtl/countdown_timer_if.sv
// Control/status bundle between the anti-theft FSM (master) and the countdown timer (slave).
// The FSM drives start_timer/value and watches expired, busy, remaining and the 1 Hz tick.
interface countdown_timer_if;
    logic       start_timer;
    logic [3:0] value;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;
    logic       one_hz_enable;

    modport master (
        output start_timer, value,
        input  expired, busy, remaining, one_hz_enable
    );

    modport slave (
        input  start_timer, value,
        output expired, busy, remaining, one_hz_enable
    );
endinterface

// File: rtl/countdown_timer.sv
// Interval countdown with a free-running 1 Hz divider. Emits a one-cycle expired pulse
// when the interval elapses. The interval length is sampled one cycle after start.
module countdown_timer #(
    parameter int CLK_HZ = 27_000_000,
    parameter int DIV_W  = 25
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   tmr
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_remaining;
    logic [3:0]       w_remaining_nxt;
    logic             r_expired;
    logic             w_tick;

    assign w_tick = (r_div_cnt == DIV_MAX);

    // Restart beats every other transition, including a tick or leaving DONE.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        if (tmr.start_timer) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_LOAD: begin
                    if (tmr.value == 4'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_remaining_nxt = tmr.value;
                        w_state_nxt     = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_tick) begin
                        if (r_remaining == 4'd1) begin
                            w_remaining_nxt = 4'd0;
                            w_state_nxt     = S_DONE;
                        end else begin
                            w_remaining_nxt = r_remaining - 4'd1;
                        end
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A restart zeroes the divider so the first counted second is a full second.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_remaining <= 4'd0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_expired   <= (w_state_nxt == S_DONE);
            r_div_cnt   <= (tmr.start_timer || w_tick) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    assign tmr.expired       = r_expired;
    assign tmr.busy          = (r_state == S_LOAD) || (r_state == S_RUN);
    assign tmr.remaining     = r_remaining;
    assign tmr.one_hz_enable = w_tick;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a timing-formula model predicts outputs after each edge,
// a separate monitor compares them half a cycle later.
module tb_countdown_timer;

    localparam int CLK_HZ = 4;
    localparam int DIV_W  = 3;

    typedef struct packed {
        logic [3:0] remaining;
        logic       busy;
        logic       expired;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    countdown_timer_if bus ();

    countdown_timer #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: an interval is described only by the edge count since start (n)
    // and the sampled length (v); outputs follow from the documented timing formulas.
    initial begin : model
        bit         active = 1'b0;
        int         n = 0;
        int         v = 0;
        int         d = 0;
        logic [3:0] rem = 4'd0;
        exp_t       e;
        forever begin
            @(posedge clk);
            e = '0;
            if (reset) begin
                active = 1'b0;
                rem    = 4'd0;
                d      = 0;
            end else if (bus.start_timer) begin
                active = 1'b1;
                n      = 0;
                d      = 0;
                e.busy = 1'b1;
            end else begin
                d = (d + 1) % CLK_HZ;
                if (active) begin
                    n = n + 1;
                    if (n == 1) v = int'(bus.value);
                    if (v == 0) begin
                        e.expired = 1'b1;
                        active    = 1'b0;
                    end else if (n < v * CLK_HZ) begin
                        e.busy = 1'b1;
                        rem    = 4'(v - n / CLK_HZ);
                    end else begin
                        e.expired = 1'b1;
                        rem       = 4'd0;
                        active    = 1'b0;
                    end
                end
            end
            e.remaining = rem;
            e.tick      = (d == CLK_HZ - 1);
            sb_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {bus.remaining, bus.busy, bus.expired, bus.one_hz_enable};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got rem=%0d busy=%b exp=%b tick=%b, expected rem=%0d busy=%b exp=%b tick=%b",
                             $time, a.remaining, a.busy, a.expired, a.tick,
                             e.remaining, e.busy, e.expired, e.tick);
                end
            end
        end
    end

    task automatic step(input logic s, input logic [3:0] v);
        @(negedge clk);
        #1;
        bus.start_timer = s;
        bus.value       = v;
    endtask

    task automatic idle(input int n, input logic [3:0] v);
        for (int i = 0; i < n; i++) step(1'b0, v);
    endtask

    // Reset raised between edges must clear the outputs before any clock edge.
    task automatic async_reset;
        @(negedge clk);
        #1;
        reset           = 1'b1;
        bus.start_timer = 1'b0;
        #1;
        checks++;
        if ({bus.remaining, bus.busy, bus.expired, bus.one_hz_enable} !== 7'd0) begin
            errors++;
            $display("FAIL async_reset: got rem=%0d busy=%b exp=%b tick=%b, expected all 0",
                     bus.remaining, bus.busy, bus.expired, bus.one_hz_enable);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : stimulus
        logic [3:0] rv;
        int         gap;
        bus.start_timer = 1'b0;
        bus.value       = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        idle(3, 4'd0);

        // mid-cycle reset from idle, then the directed intervals
        async_reset();
        step(1'b1, 4'd3); idle(16, 4'd3);
        step(1'b1, 4'd0); idle(4, 4'd0);
        step(1'b1, 4'd5); idle(2, 4'd5); idle(24, 4'd2);
        step(1'b1, 4'd4); idle(5, 4'd4); step(1'b1, 4'd4); idle(20, 4'd4);
        step(1'b1, 4'd3); idle(4, 4'd3); async_reset(); idle(15, 4'd3);
        step(1'b1, 4'd3); idle(16, 4'd3);
        // start held high: stays in LOAD with the divider pinned
        step(1'b1, 4'd2); step(1'b1, 4'd7); step(1'b1, 4'd1); idle(8, 4'd9);
        // max interval
        step(1'b1, 4'd15); idle(64, 4'd15);

        for (int it = 0; it < 60; it++) begin
            rv = 4'($urandom_range(0, 15));
            for (int h = 0; h < int'($urandom_range(1, 2)); h++) step(1'b1, 4'($urandom));
            step(1'b0, rv);
            gap = int'($urandom_range(0, int'(rv) * CLK_HZ + 6));
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 99) < 2) async_reset();
                else step(1'b0, 4'($urandom));
            end
        end
        idle(70, 4'd0);

        checks++;
        if (sb_q.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected at most 1", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
